debruijn_gen: RTL and testbench
===============================

DEBRUIJN_GEN -- requirements
Module: debruijn_gen

Interface
REQ-001 Parameter ORDER, default 4: sequence order n, giving period 2^n bits; legal range 2..8.
REQ-002 Parameter TAPS, default 4'b1100: ORDER-bit feedback tap mask, which SHALL describe a maximal-length polynomial (4'b1100 = x^4+x^3+1).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port start, input, 1: load seed and begin a pass.
REQ-007 Port seed, input, ORDER: initial window state, sampled only when start=1.
REQ-008 Port en, input, 1: advance one sequence bit per cycle while RUN.
REQ-009 Port loop, input, 1: 1 = free-running, 0 = stop after one period.
REQ-010 Port bit_out, output, 1: current sequence bit, window[ORDER-1]; drives the sel input of the downstream 2:1 mux stage.
REQ-011 Port window, output, ORDER: current n-bit window state.
REQ-012 Port valid, output, 1: bit_out is a live sequence bit.
REQ-013 Port count, output, ORDER: bits emitted in the current period, 0..2^ORDER-1.
REQ-014 Port done, output, 1: one-cycle pulse marking period completion.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and HOLD, encoded in 2 bits.
REQ-016 All outputs SHALL be registered.
REQ-017 Feedback SHALL be fb = (^(window & TAPS)) XOR (window[ORDER-2:0] == 0); next window = {window[ORDER-2:0], fb}.
REQ-018 The zero-insertion term in REQ-017 SHALL make the window visit all 2^ORDER states, including all-zeros, exactly once per period.
REQ-019 IDLE: valid=0 and done=0; start=1 SHALL load window<=seed, set count<=0 and enter RUN.
REQ-020 RUN, en=0: window, count, valid=1 and bit_out SHALL hold; done=0.
REQ-021 RUN, en=1, count<2^ORDER-1: window SHALL advance per REQ-017 and count SHALL increment by 1.
REQ-022 RUN, en=1, count=2^ORDER-1: window SHALL advance (returning to seed), count SHALL wrap to 0 and done SHALL be 1 in the next cycle only.
REQ-023 In the REQ-022 case, the FSM SHALL stay in RUN if loop=1 and go to HOLD if loop=0.
REQ-024 HOLD: valid=0 and window holds (equal to seed); start=1 SHALL reload and enter RUN; en SHALL be ignored.
REQ-025 start=1 in RUN SHALL take priority over en: reload seed, count<=0, done=0, remain RUN.
REQ-026 Latency: the first sequence bit SHALL appear on bit_out, with valid=1, one cycle after start is sampled.
REQ-027 Each en=1 cycle in RUN SHALL produce the next bit one cycle later.
REQ-028 loop SHALL be sampled only at the wrap cycle.
REQ-029 The emitted bit sequence SHALL depend on seed only as a rotation of the single de Bruijn cycle.

Reset
REQ-030 reset=1 SHALL force state=IDLE, window=0, count=0, valid=0, done=0 and bit_out=0 at the next clock edge.
REQ-031 reset SHALL override start and en, including mid-RUN, with no residual done pulse.

Verification
REQ-032 ORDER=4, seed=0000, loop=0, start then en=1 for 16 cycles -> bit_out over 16 valid cycles = 0000100110101111; done pulses once; valid drops; window=0000; state HOLD.
REQ-033 seed=0000, loop=0 -> window trace 0000,0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000; all 16 values are distinct.
REQ-034 seed=1000, loop=1, en=1 for 48 cycles -> done pulses at cycles 16, 32 and 48; the bit stream repeats with period 16; valid stays 1 throughout.
REQ-035 en toggled 1,0,0,1,... in RUN -> window and count freeze on en=0 cycles; the 16 emitted bits still match REQ-032 once the rotation for the seed is applied.
REQ-036 Reset asserted at count=7 -> outputs at reset values next cycle; a following start with seed=0000 restarts from count=0 and bit 0.
REQ-037 start reasserted at count=10 in RUN -> window<=seed, count=0, no done pulse, sequence restarts.

Source files
------------

// File: rtl/debruijn_gen_if.sv
// Bundle of the de Bruijn generator's control inputs and registered outputs.
// Handshake: there is no ready; bit_out is a live sequence bit exactly when
// valid=1, and the consumer must accept it in that cycle (it holds while en=0).
// state is a debug view of the generator FSM: 0=IDLE, 1=RUN, 2=HOLD.
interface debruijn_gen_if #(
    parameter int ORDER = 4
);
    logic             start;
    logic [ORDER-1:0] seed;
    logic             en;
    logic             loop;
    logic             bit_out;
    logic [ORDER-1:0] window;
    logic             valid;
    logic [ORDER-1:0] count;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, seed, en, loop,
        input  bit_out, window, valid, count, done, state
    );

    modport slave (
        input  start, seed, en, loop,
        output bit_out, window, valid, count, done, state
    );
endinterface

// File: rtl/debruijn_gen.sv
// De Bruijn sequence generator: a maximal-length LFSR with a zero-insertion
// term so the ORDER-bit window walks all 2^ORDER states, including all-zeros,
// once per period. The sequence bit is the window MSB.
module debruijn_gen #(
    parameter int               ORDER = 4,
    parameter logic [ORDER-1:0] TAPS  = 4'b1100
) (
    input  logic               clk,
    input  logic               reset,
    debruijn_gen_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Last count value of a period; reaching it with en=1 closes the period.
    localparam logic [ORDER-1:0] CNT_MAX = '1;

    state_t           state_q, state_n;
    logic [ORDER-1:0] window_q, window_n;
    logic [ORDER-1:0] count_q, count_n;
    logic             valid_q, valid_n;
    logic             done_q, done_n;
    logic             fb;
    logic [ORDER-1:0] window_adv;

    // Feedback: LFSR parity plus the zero-insertion term that splices the
    // all-zeros state between 10..0 and 0..01.
    always_comb begin
        fb         = (^(window_q & TAPS)) ^ (window_q[ORDER-2:0] == '0);
        window_adv = {window_q[ORDER-2:0], fb};
    end

    // Next-state and next-output logic; done is a pulse so it defaults low.
    always_comb begin
        state_n  = state_q;
        window_n = window_q;
        count_n  = count_q;
        valid_n  = valid_q;
        done_n   = 1'b0;
        case (state_q)
            S_IDLE, S_HOLD: begin
                valid_n = 1'b0;
                if (bus.start) begin
                    window_n = bus.seed;
                    count_n  = '0;
                    valid_n  = 1'b1;
                    state_n  = S_RUN;
                end
            end
            S_RUN: begin
                valid_n = 1'b1;
                if (bus.start) begin
                    window_n = bus.seed;
                    count_n  = '0;
                end else if (bus.en) begin
                    window_n = window_adv;
                    if (count_q == CNT_MAX) begin
                        count_n = '0;
                        done_n  = 1'b1;
                        // loop only matters here, at the wrap.
                        if (!bus.loop) begin
                            state_n = S_HOLD;
                            valid_n = 1'b0;
                        end
                    end else begin
                        count_n = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n  = S_IDLE;
                window_n = '0;
                count_n  = '0;
                valid_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides start and en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            window_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            window_q <= window_n;
            count_q  <= count_n;
            valid_q  <= valid_n;
            done_q   <= done_n;
        end
    end

    assign bus.bit_out = window_q[ORDER-1];
    assign bus.window  = window_q;
    assign bus.count   = count_q;
    assign bus.valid   = valid_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_debruijn_gen.sv
// Testbench for debruijn_gen (ORDER=4, TAPS=4'b1100). The reference model
// treats the output as a rotation of the de Bruijn string 0000100110101111:
// the window is the 4-bit slice of that cyclic string at the current position.
module tb_debruijn_gen;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic clk;
    logic reset;

    debruijn_gen_if #(.ORDER(4)) bus ();

    debruijn_gen #(.ORDER(4), .TAPS(4'b1100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] db_seq = 16'b0000100110101111;  // string index 0 is the MSB
    logic [1:0]  m_state;
    int          m_pos;
    int          m_count;
    logic        m_valid;
    logic        m_done;

    int n_vec  = 0;
    int n_miss = 0;
    logic [3:0] exp_q[$];

    function automatic logic db_bit(input int i);
        return db_seq[15 - (i % 16)];
    endfunction

    function automatic logic [3:0] win_at(input int p);
        logic [3:0] w;
        for (int i = 0; i < 4; i++) w[3-i] = db_bit(p + i);
        return w;
    endfunction

    function automatic int find_pos(input logic [3:0] s);
        for (int p = 0; p < 16; p++) if (win_at(p) == s) return p;
        return 0;
    endfunction

    function automatic void model_step(input logic r, input logic st,
                                       input logic [3:0] sd, input logic e,
                                       input logic lp);
        if (r) begin
            m_state = ST_IDLE; m_pos = 0; m_count = 0; m_valid = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (m_state == ST_RUN) begin
            if (st) begin
                m_pos = find_pos(sd); m_count = 0;
            end else if (e) begin
                m_pos = (m_pos + 1) % 16;
                if (m_count == 15) begin
                    m_count = 0; m_done = 1;
                    if (!lp) begin m_state = ST_HOLD; m_valid = 0; end
                end else begin
                    m_count = m_count + 1;
                end
            end
        end else begin
            m_valid = 0;
            if (st) begin
                m_pos = find_pos(sd); m_count = 0; m_valid = 1; m_state = ST_RUN;
            end
        end
    endfunction

    // {state, valid, done, count, window, bit_out}
    function automatic logic [12:0] exp_vec();
        logic [3:0] w;
        logic [3:0] c;
        w = (m_state == ST_IDLE) ? 4'b0000 : win_at(m_pos);
        c = 4'(m_count);
        return {m_state, m_valid, m_done, c, w, w[3]};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {bus.state, bus.valid, bus.done, bus.count, bus.window, bus.bit_out};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic st, input logic [3:0] sd,
                         input logic e, input logic lp);
        @(negedge clk);
        reset     = r;
        bus.start = st;
        bus.seed  = sd;
        bus.en    = e;
        bus.loop  = lp;
        @(posedge clk);
        model_step(r, st, sd, e, lp);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_miss++;
                $display("FAIL test_reset: got %b want %b", obs_vec(), exp_vec());
            end
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_miss++;
            $display("FAIL test_reset_idle: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_pass();
        logic [15:0] bits;
        logic [3:0]  wins[16];
        int          nb;
        int          ndone;
        logic        distinct;
        nb = 0; ndone = 0; bits = '0;
        drive(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_miss++;
                $display("FAIL test_single_pass[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (bus.valid === 1'b1 && nb < 16) begin
                bits[15-nb] = bus.bit_out;
                wins[nb]    = bus.window;
                nb++;
            end
            if (bus.done === 1'b1) ndone++;
        end
        n_vec++;
        if (bits !== 16'b0000100110101111 || nb != 16 || ndone != 1) begin
            n_miss++;
            $display("FAIL test_single_pass_bits: got %b (%0d bits, %0d done) want 0000100110101111 (16 bits, 1 done)",
                     bits, nb, ndone);
        end
        distinct = 1'b1;
        for (int a = 0; a < 16; a++)
            for (int b = a + 1; b < 16; b++)
                if (wins[a] === wins[b]) distinct = 1'b0;
        n_vec++;
        if (distinct !== 1'b1 || bus.state !== ST_HOLD || bus.window !== 4'b0000) begin
            n_miss++;
            $display("FAIL test_single_pass_windows: distinct=%b state=%0d window=%b want 1 2 0000",
                     distinct, bus.state, bus.window);
        end
        // HOLD ignores en.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'b0101, 1'b1, 1'b1);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_miss++;
                $display("FAIL test_hold_ignores_en[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_loop();
        int         p0;
        int         ndone;
        logic [3:0] want;
        ndone = 0;
        p0 = find_pos(4'b1000);
        for (int k = 0; k <= 48; k++) exp_q.push_back({3'b000, db_bit(p0 + k)});
        drive(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1);
        for (int i = 0; i <= 48; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
            n_vec++;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            if (obs_vec() !== exp_vec() || bus.bit_out !== want[0] || bus.valid !== 1'b1) begin
                n_miss++;
                $display("FAIL test_loop[%0d]: got %b bit %b want %b bit %b", i, obs_vec(), bus.bit_out,
                         exp_vec(), want[0]);
            end
            if (bus.done === 1'b1) begin
                ndone++;
                n_vec++;
                if (i % 16 != 0) begin
                    n_miss++;
                    $display("FAIL test_loop_done_cycle: got done at %0d want multiple of 16", i);
                end
            end
        end
        n_vec++;
        if (ndone != 3) begin
            n_miss++;
            $display("FAIL test_loop_done_count: got %0d want 3", ndone);
        end
    endtask

    task automatic test_en_toggle();
        int ndone;
        int cyc;
        ndone = 0; cyc = 0;
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        while (ndone == 0 && cyc < 200) begin
            drive(1'b0, 1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_miss++;
                $display("FAIL test_en_toggle[%0d]: got %b want %b", cyc, obs_vec(), exp_vec());
            end
            if (bus.done === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone == 0) begin
            n_miss++;
            $display("FAIL test_en_toggle_timeout: got no done in %0d cycles want 1", cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        n_vec++;
        if (bus.count !== 4'd7) begin
            n_miss++;
            $display("FAIL test_reset_mid_count: got %0d want 7", bus.count);
        end
        drive(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_miss++;
            $display("FAIL test_reset_mid: got %b want %b", obs_vec(), exp_vec());
        end
        drive(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_miss++;
            $display("FAIL test_reset_mid_restart: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_restart();
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            else        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_miss++;
                $display("FAIL test_restart[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_miss++;
                $display("FAIL test_random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.seed  = '0;
        bus.en    = 1'b0;
        bus.loop  = 1'b0;
        m_state = ST_IDLE; m_pos = 0; m_count = 0; m_valid = 0; m_done = 0;
        test_reset();
        test_single_pass();
        test_loop();
        test_en_toggle();
        test_reset_mid_run();
        test_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
